// File: rtl/id_buf_pkg.sv
// Shared defaults and entry layout for the two-channel ID buffer.
package id_buf_pkg;

  localparam int unsigned ID_W_DEF     = 8;
  localparam int unsigned COL_W_DEF    = 3;
  localparam int unsigned NUM_COLS_DEF = 8;
  localparam int unsigned DEPTH_DEF    = 4;
  localparam int unsigned ENTRY_W      = COL_W_DEF + ID_W_DEF;

  // Queued entry: column stamp in the upper bits, ID below.
  typedef struct packed {
    logic [COL_W_DEF-1:0] col;
    logic [ID_W_DEF-1:0]  id;
  } id_entry_t;

endpackage

// File: rtl/id_chan_slice.sv
// One channel: ID FIFO, current/prev transmit registers and status flags.
module id_chan_slice
  import id_buf_pkg::*;
#(
  parameter int unsigned EW    = ENTRY_W,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [EW-1:0] push_data_i,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic          flush_i,
  input  logic          clear_prev_i,
  output logic          full_o,
  output logic          empty_o,
  output logic          empty_prev_o,
  output logic [EW-1:0] cur_data_o,
  output logic [EW-1:0] prev_data_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [EW-1:0] cur_q, cur_d, prev_q, prev_d;
  logic          cur_v_q, cur_v_d, prev_v_q, prev_v_d;
  logic          fifo_empty, push, pop;

  assign fifo_empty = (cnt_q == '0);
  assign full_o     = (cnt_q == (PW+1)'(DEPTH));
  assign push       = push_i & ~full_o & ~flush_i;
  assign pop        = load_i & ~fifo_empty & ~flush_i;

  // FIFO pointer/count update; a flush overrides any push or pop.
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Cur/prev update; clear reads the old cur so load+clear shifts cur into prev.
  always_comb begin
    cur_d    = cur_q;
    cur_v_d  = cur_v_q;
    prev_d   = prev_q;
    prev_v_d = prev_v_q;
    if (clear_i) begin
      prev_d   = cur_q;
      prev_v_d = cur_v_q;
    end else if (clear_prev_i) begin
      prev_v_d = 1'b0;
    end
    if (pop) begin
      cur_d   = mem_q[rptr_q];
      cur_v_d = 1'b1;
    end else if (clear_i) begin
      cur_v_d = 1'b0;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q   <= '0;
      wptr_q   <= '0;
      cnt_q    <= '0;
      cur_q    <= '0;
      cur_v_q  <= 1'b0;
      prev_q   <= '0;
      prev_v_q <= 1'b0;
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      cur_v_q  <= cur_v_d;
      prev_q   <= prev_d;
      prev_v_q <= prev_v_d;
    end
  end

  assign empty_o      = fifo_empty & ~cur_v_q;
  assign empty_prev_o = ~prev_v_q;
  assign cur_data_o   = cur_q;
  assign prev_data_o  = prev_q;

endmodule

// File: rtl/id_channel_buffer.sv
// Two-channel ID queue: column stamping, push steering and per-channel slices.
module id_channel_buffer
  import id_buf_pkg::*;
#(
  parameter int unsigned ID_W     = ID_W_DEF,
  parameter int unsigned COL_W    = COL_W_DEF,
  parameter int unsigned NUM_COLS = NUM_COLS_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_W-1:0]       id_in,
  input  logic                  id_ch,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic                  loadID1,
  input  logic                  loadID2,
  input  logic                  clearID1,
  input  logic                  clearID2,
  input  logic                  resetID1,
  input  logic                  resetID2,
  input  logic                  clearID1_prev,
  input  logic                  clearID2_prev,
  input  logic                  restart_col_select,
  output logic                  emptyID1,
  output logic                  emptyID2,
  output logic                  emptyID1_prev,
  output logic                  emptyID2_prev,
  output logic [COL_W+ID_W-1:0] tx1_data,
  output logic [COL_W+ID_W-1:0] tx2_data,
  output logic [COL_W+ID_W-1:0] tx1_prev_data,
  output logic [COL_W+ID_W-1:0] tx2_prev_data,
  output logic [COL_W-1:0]      col_sel
);

  localparam int unsigned EW = COL_W + ID_W;

  logic [COL_W-1:0] col_q, col_d;
  logic             full1, full2, accept, push1, push2;
  logic [EW-1:0]    entry;

  assign id_ready = id_ch ? (~full2 & ~resetID2) : (~full1 & ~resetID1);
  assign accept   = id_valid & id_ready;
  assign push1    = accept & ~id_ch;
  assign push2    = accept & id_ch;
  assign entry    = {col_q, id_in};

  // Column select: restart wins over the per-push increment.
  always_comb begin
    col_d = col_q;
    if (restart_col_select) begin
      col_d = '0;
    end else if (accept) begin
      col_d = (col_q == COL_W'(NUM_COLS - 1)) ? '0 : col_q + 1'b1;
    end
  end

  // Column select register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) col_q <= '0;
    else        col_q <= col_d;
  end

  assign col_sel = col_q;

  id_chan_slice #(.EW(EW), .DEPTH(DEPTH)) u_ch1 (
    .clk_i        (clk),
    .rst_ni       (reset),
    .push_i       (push1),
    .push_data_i  (entry),
    .load_i       (loadID1),
    .clear_i      (clearID1),
    .flush_i      (resetID1),
    .clear_prev_i (clearID1_prev),
    .full_o       (full1),
    .empty_o      (emptyID1),
    .empty_prev_o (emptyID1_prev),
    .cur_data_o   (tx1_data),
    .prev_data_o  (tx1_prev_data)
  );

  id_chan_slice #(.EW(EW), .DEPTH(DEPTH)) u_ch2 (
    .clk_i        (clk),
    .rst_ni       (reset),
    .push_i       (push2),
    .push_data_i  (entry),
    .load_i       (loadID2),
    .clear_i      (clearID2),
    .flush_i      (resetID2),
    .clear_prev_i (clearID2_prev),
    .full_o       (full2),
    .empty_o      (emptyID2),
    .empty_prev_o (emptyID2_prev),
    .cur_data_o   (tx2_data),
    .prev_data_o  (tx2_prev_data)
  );

endmodule
